// File: rtl/sys_bridge.sv
// System bridge: decodes CPU M-stage bus accesses to data memory or two timers,
// returns read data combinationally, and builds the HWInt vector for CP0.
module sys_bridge #(
    parameter logic [31:0] DM_TOP   = 32'h0000_2FFF,
    parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
    parameter logic [31:0] TC1_BASE = 32'h0000_7F10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PrAddr,
    input  logic [31:0] PrWD,
    input  logic [3:0]  Prbeen,
    input  logic        PrWE,
    output logic [31:0] PrRD,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    input  logic [31:0] m_data_rdata,
    input  logic        ext_irq,
    output logic [5:0]  HWInt
);

    typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} tc_state_e;

    logic              dm_hit;
    logic              wr_full;
    logic [1:0]        tc_hit;
    logic [1:0][31:0]  tc_off;
    logic [1:0][3:0]   ctrl_q, ctrl_d;
    logic [1:0][31:0]  preset_q, preset_d;
    logic [1:0][31:0]  count_q, count_d;
    logic [1:0]        irq_q, irq_d;
    logic [1:0]        irq;
    tc_state_e         st_q [2];
    tc_state_e         st_d [2];

    // Unsigned offset wraps high when PrAddr is below the base, so one compare covers both ends.
    assign tc_off[0] = PrAddr - TC0_BASE;
    assign tc_off[1] = PrAddr - TC1_BASE;
    assign dm_hit    = (PrAddr <= DM_TOP);
    assign wr_full   = PrWE && (Prbeen == 4'b1111);

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            tc_hit[i] = !dm_hit && (tc_off[i] <= 32'd8) && (PrAddr[1:0] == 2'b00);
        end
    end

    assign m_data_addr   = PrAddr;
    assign m_data_wdata  = PrWD;
    assign m_data_byteen = (PrWE && dm_hit) ? Prbeen : 4'b0000;

    always_comb begin
        PrRD = 32'd0;
        if (dm_hit) begin
            PrRD = m_data_rdata;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (tc_hit[i]) begin
                    case (tc_off[i][3:2])
                        2'd0:    PrRD = {28'd0, ctrl_q[i]};
                        2'd1:    PrRD = preset_q[i];
                        2'd2:    PrRD = count_q[i];
                        default: PrRD = 32'd0;
                    endcase
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ctrl_d[i]   = ctrl_q[i];
            preset_d[i] = preset_q[i];
            count_d[i]  = count_q[i];
            irq_d[i]    = irq_q[i];
            st_d[i]     = st_q[i];
            case (st_q[i])
                StIdle: if (ctrl_q[i][0]) st_d[i] = StLoad;
                StLoad: begin
                    count_d[i] = preset_q[i];
                    st_d[i]    = StCnt;
                end
                StCnt: begin
                    if (!ctrl_q[i][0]) begin
                        st_d[i] = StIdle;
                    end else if (count_q[i] > 32'd1) begin
                        count_d[i] = count_q[i] - 32'd1;
                    end else begin
                        count_d[i] = 32'd0;
                        irq_d[i]   = 1'b1;
                        st_d[i]    = StInt;
                    end
                end
                StInt: begin
                    if (ctrl_q[i][2:1] == 2'b01) begin
                        irq_d[i] = 1'b0;
                        st_d[i]  = StLoad;
                    end else begin
                        ctrl_d[i][0] = 1'b0;
                        st_d[i]      = StIdle;
                    end
                end
                default: st_d[i] = StIdle;
            endcase
            // CPU writes are applied last so they win over the FSM's EN clear.
            if (wr_full && tc_hit[i]) begin
                if (tc_off[i][3:2] == 2'd0) begin
                    ctrl_d[i] = PrWD[3:0];
                    irq_d[i]  = 1'b0;
                end else if (tc_off[i][3:2] == 2'd1) begin
                    preset_d[i] = PrWD;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                ctrl_q[i]   <= 4'd0;
                preset_q[i] <= 32'd0;
                count_q[i]  <= 32'd0;
                irq_q[i]    <= 1'b0;
                st_q[i]     <= StIdle;
            end else begin
                ctrl_q[i]   <= ctrl_d[i];
                preset_q[i] <= preset_d[i];
                count_q[i]  <= count_d[i];
                irq_q[i]    <= irq_d[i];
                st_q[i]     <= st_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            irq[i] = irq_q[i] & ctrl_q[i][3];
        end
    end

    assign HWInt = {3'b000, ext_irq, irq[1], irq[0]};

endmodule
